// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 timing constants for the VGA compositor.
package vga_pkg;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb332_t;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;
    localparam int unsigned CLK_DIV_DEF  = 2;

    localparam rgb332_t BLACK      = '0;
    localparam rgb332_t BG_DEFAULT = '{r: 3'b001, g: 3'b000, b: 2'b01};

    function automatic rgb332_t scanline_dim(input rgb332_t c);
        return '{r: c.r >> 1, g: c.g >> 1, b: c.b >> 1};
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// VGA timing: pixel clock-enable divider, h/v counters, raw sync and active flags.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter int unsigned CLK_DIV  = CLK_DIV_DEF
) (
    input  logic       clk50M,
    input  logic       reset,
    output logic       pix_en,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       hsync_on,
    output logic       vsync_on,
    output logic       active
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1) begin : g_bad_timing
        $error("vga_timing_gen: H_TOTAL/V_TOTAL must be <= 1024 and CLK_DIV >= 1");
    end

    logic [DIV_W-1:0] div_q, div_d;
    logic             pix_en_q, pix_en_d;
    logic [9:0]       hcount_q, hcount_d;
    logic [9:0]       vcount_q, vcount_d;

    // pix_en is registered from the next divider value so it stays low in reset
    // and is constantly high after reset when CLK_DIV is 1.
    always_comb begin
        div_d    = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        pix_en_d = (div_d == DIV_LAST);
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (pix_en_q) begin
            if (hcount_q == H_LAST) begin
                hcount_d = '0;
                vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 10'd1;
            end else begin
                hcount_d = hcount_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk50M or negedge reset) begin
        if (!reset) begin
            div_q    <= '0;
            pix_en_q <= 1'b0;
            hcount_q <= '0;
            vcount_q <= '0;
        end else begin
            div_q    <= div_d;
            pix_en_q <= pix_en_d;
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
        end
    end

    assign pix_en   = pix_en_q;
    assign hcount   = hcount_q;
    assign vcount   = vcount_q;
    assign hsync_on = (hcount_q >= HS_FIRST) && (hcount_q <= HS_LAST);
    assign vsync_on = (vcount_q >= VS_FIRST) && (vcount_q <= VS_LAST);
    assign active   = ({1'b0, hcount_q} < 11'(H_ACTIVE)) && ({1'b0, vcount_q} < 11'(V_ACTIVE));

endmodule

// File: rtl/vga_compositor.sv
// Priority layer compositor with registered RGB332/sync outputs.
// Optional scanline dimming on odd active lines: VGA_COMPOSITOR_SCANLINE_EN.
module vga_compositor
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
    parameter int unsigned H_FP       = H_FP_DEF,
    parameter int unsigned H_SYNC     = H_SYNC_DEF,
    parameter int unsigned H_BP       = H_BP_DEF,
    parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
    parameter int unsigned V_FP       = V_FP_DEF,
    parameter int unsigned V_SYNC     = V_SYNC_DEF,
    parameter int unsigned V_BP       = V_BP_DEF,
    parameter int unsigned NUM_LAYERS = 4,
    parameter int unsigned CLK_DIV    = CLK_DIV_DEF,
    parameter logic [7:0]  BG_COLOR   = BG_DEFAULT,
    parameter bit          SYNC_POL   = 1'b0
) (
    input  logic                    clk50M,
    input  logic                    reset,
    input  logic [NUM_LAYERS-1:0]   layer_on,
    input  logic [8*NUM_LAYERS-1:0] layer_rgb,
    output logic [9:0]              xpixel,
    output logic [9:0]              ypixel,
    output logic                    pix_en,
    output logic [2:0]              red,
    output logic [2:0]              green,
    output logic [1:0]              blue,
    output logic                    HS,
    output logic                    VS,
    output logic                    endofframe
);

    if (NUM_LAYERS < 1 || NUM_LAYERS > 8) begin : g_bad_layers
        $error("vga_compositor: NUM_LAYERS must be in 1..8");
    end

    logic       hsync_on, vsync_on, active;
    logic [9:0] hcount, vcount;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .CLK_DIV  (CLK_DIV)
    ) u_timing (
        .clk50M   (clk50M),
        .reset    (reset),
        .pix_en   (pix_en),
        .hcount   (hcount),
        .vcount   (vcount),
        .hsync_on (hsync_on),
        .vsync_on (vsync_on),
        .active   (active)
    );

    rgb332_t composite;
    rgb332_t pixel;
    rgb332_t rgb_q, rgb_d;
    logic    hs_q, hs_d;
    logic    vs_q, vs_d;
    logic    eof_q, eof_d;
    logic    found;

    always_comb begin
        composite = BG_COLOR;
        found     = 1'b0;
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            if (!found && layer_on[i]) begin
                composite = layer_rgb[8*i +: 8];
                found     = 1'b1;
            end
        end
    end

    always_comb begin
        pixel = active ? composite : BLACK;
`ifdef VGA_COMPOSITOR_SCANLINE_EN
        if (active && vcount[0]) begin
            pixel = scanline_dim(pixel);
        end
`endif
        rgb_d = rgb_q;
        hs_d  = hs_q;
        vs_d  = vs_q;
        eof_d = eof_q;
        if (pix_en) begin
            rgb_d = pixel;
            hs_d  = hsync_on ? SYNC_POL : ~SYNC_POL;
            vs_d  = vsync_on ? SYNC_POL : ~SYNC_POL;
            eof_d = (hcount == '0) && ({1'b0, vcount} == 11'(V_ACTIVE));
        end
    end

    always_ff @(posedge clk50M or negedge reset) begin
        if (!reset) begin
            rgb_q <= BLACK;
            hs_q  <= ~SYNC_POL;
            vs_q  <= ~SYNC_POL;
            eof_q <= 1'b0;
        end else begin
            rgb_q <= rgb_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            eof_q <= eof_d;
        end
    end

    assign xpixel     = hcount;
    assign ypixel     = vcount;
    assign red        = rgb_q.r;
    assign green      = rgb_q.g;
    assign blue       = rgb_q.b;
    assign HS         = hs_q;
    assign VS         = vs_q;
    assign endofframe = eof_q;

endmodule
